// File: rtl/pipe_inst_enc.sv
// Instruction encoder: packs symbolic instructions into 32-bit words and streams them
// through a 2-entry FIFO to the imem load port. Optional word counter: PIPE_ENC_CNT_EN.
module pipe_inst_enc #(
   parameter int          AW        = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_sel,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_sa,
   input  logic [15:0]   in_imm,
   input  logic [25:0]   in_target,
   input  logic          ld_addr,
   input  logic [AW-1:0] addr_in,
   output logic          im_we,
   input  logic          im_ready,
   output logic [AW-1:0] im_addr,
   output logic [31:0]   im_wdata,
   output logic          err,
   output logic          err_sticky,
   output logic          wrapped,
`ifdef PIPE_ENC_CNT_EN
   output logic [15:0]   wcount,
`endif
   input  logic          clr
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_SH  = 3'd1;
   localparam logic [2:0] FMT_JR  = 3'd2;
   localparam logic [2:0] FMT_I   = 3'd3;
   localparam logic [2:0] FMT_LUI = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;

   // Returns {valid, word}; the word is don't-care when the class is invalid.
   function automatic logic [32:0] encode(
      input logic [4:0]  sel,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  sa,
      input logic [15:0] imm,
      input logic [25:0] tgt
   );
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [2:0]  fmt;
      logic        ok;
      logic [31:0] w;
      op  = 6'd0;
      fn  = 6'd0;
      fmt = FMT_R;
      ok  = 1'b1;
      case (sel)
         5'd0:  begin op = 6'b000000; fn = 6'd1; fmt = FMT_R;   end
         5'd1:  begin op = 6'b000000; fn = 6'd2; fmt = FMT_R;   end
         5'd2:  begin op = 6'b000000; fn = 6'd3; fmt = FMT_R;   end
         5'd3:  begin op = 6'b000001; fn = 6'd1; fmt = FMT_R;   end
         5'd4:  begin op = 6'b000001; fn = 6'd2; fmt = FMT_R;   end
         5'd5:  begin op = 6'b000001; fn = 6'd4; fmt = FMT_R;   end
         5'd6:  begin op = 6'b000010; fn = 6'd1; fmt = FMT_SH;  end
         5'd7:  begin op = 6'b000010; fn = 6'd2; fmt = FMT_SH;  end
         5'd8:  begin op = 6'b000010; fn = 6'd3; fmt = FMT_SH;  end
         5'd9:  begin op = 6'b000010; fn = 6'd4; fmt = FMT_JR;  end
         5'd10: begin op = 6'b000101; fmt = FMT_I;   end
         5'd11: begin op = 6'b000111; fmt = FMT_I;   end
         5'd12: begin op = 6'b001001; fmt = FMT_I;   end
         5'd13: begin op = 6'b001010; fmt = FMT_I;   end
         5'd14: begin op = 6'b001100; fmt = FMT_I;   end
         5'd15: begin op = 6'b001101; fmt = FMT_I;   end
         5'd16: begin op = 6'b001110; fmt = FMT_I;   end
         5'd17: begin op = 6'b001111; fmt = FMT_I;   end
         5'd18: begin op = 6'b010000; fmt = FMT_I;   end
         5'd19: begin op = 6'b010001; fmt = FMT_LUI; end
         5'd20: begin op = 6'b010010; fmt = FMT_J;   end
         5'd21: begin op = 6'b010011; fmt = FMT_J;   end
         default: ok = 1'b0;
      endcase
      case (fmt)
         FMT_R:   w = {op, rs, rt, rd, 5'd0, fn};
         FMT_SH:  w = {op, 5'd0, rt, rd, sa, fn};
         FMT_JR:  w = {op, rs, 15'd0, fn};
         FMT_I:   w = {op, rs, rt, imm};
         FMT_LUI: w = {op, 5'd0, rt, imm};
         FMT_J:   w = {op, tgt};
         default: w = 32'd0;
      endcase
      return {ok, w};
   endfunction

   logic [31:0]   mem_q [2];
   logic          head_q, head_d;
   logic          tail_q, tail_d;
   logic [1:0]    count_q, count_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          err_q, err_d;
   logic          sticky_q, sticky_d;
   logic          wrap_q, wrap_d;
   logic [32:0]   enc_s;
   logic          accept_s, push_s, pop_s;

   assign in_ready   = (count_q != 2'd2);
   assign im_we      = (count_q != 2'd0);
   assign im_wdata   = mem_q[head_q];
   assign im_addr    = ptr_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;
   assign wrapped    = wrap_q;

   // Next-state: FIFO bookkeeping, write pointer and status flags.
   always_comb begin
      enc_s    = encode(in_sel, in_rs, in_rt, in_rd, in_sa, in_imm, in_target);
      accept_s = in_valid & in_ready;
      push_s   = accept_s & enc_s[32];
      pop_s    = im_we & im_ready;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      ptr_d    = ptr_q;
      wrap_d   = wrap_q;
      sticky_d = sticky_q;
      err_d    = accept_s & ~enc_s[32];
      if (pop_s) begin
         head_d = ~head_q;
      end else begin
         head_d = head_q;
      end
      if (push_s) begin
         tail_d = ~tail_q;
      end else begin
         tail_d = tail_q;
      end
      if (push_s && !pop_s) begin
         count_d = count_q + 2'd1;
      end else if (pop_s && !push_s) begin
         count_d = count_q - 2'd1;
      end else begin
         count_d = count_q;
      end
      // A load wins over the increment, so it also suppresses the wrap flag.
      if (ld_addr) begin
         ptr_d = addr_in;
      end else if (pop_s) begin
         ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         ptr_d = ptr_q;
      end
      if (pop_s && !ld_addr && (ptr_q == {AW{1'b1}})) begin
         wrap_d = 1'b1;
      end else if (clr) begin
         wrap_d = 1'b0;
      end else begin
         wrap_d = wrap_q;
      end
      if (err_d) begin
         sticky_d = 1'b1;
      end else if (clr) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // State registers; reset discards FIFO contents and reloads the base address.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mem_q[0] <= 32'd0;
         mem_q[1] <= 32'd0;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
         count_q  <= 2'd0;
         ptr_q    <= AW'(BASE_ADDR);
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         if (push_s) begin
            mem_q[tail_q] <= enc_s[31:0];
         end
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         ptr_q    <= ptr_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         wrap_q   <= wrap_d;
      end
   end

`ifdef PIPE_ENC_CNT_EN
   logic [15:0] wcount_q;
   assign wcount = wcount_q;

   // Saturating transfer counter; clr takes precedence over a same-cycle transfer.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wcount_q <= 16'd0;
      end else if (clr) begin
         wcount_q <= 16'd0;
      end else if (pop_s && (wcount_q != 16'hFFFF)) begin
         wcount_q <= wcount_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_inst_enc.sv
// Self-checking bench for pipe_inst_enc: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pipe_inst_enc;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_sel = 5'd0, in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_sa = 5'd0;
   logic [15:0] in_imm = 16'd0;
   logic [25:0] in_target = 26'd0;
   logic        ld_addr = 1'b0;
   logic [7:0]  addr_in = 8'd0;
   logic        im_we;
   logic        im_ready = 1'b0;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;
   logic        err, err_sticky, wrapped;
   logic        clr = 1'b0;
`ifdef PIPE_ENC_CNT_EN
   logic [15:0] wcount;
`endif

   int errors = 0;
   int checks = 0;

   pipe_inst_enc #(.AW(8), .BASE_ADDR(0)) dut (
      .clock(clock), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
      .in_imm(in_imm), .in_target(in_target),
      .ld_addr(ld_addr), .addr_in(addr_in),
      .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
      .err(err), .err_sticky(err_sticky), .wrapped(wrapped),
`ifdef PIPE_ENC_CNT_EN
      .wcount(wcount),
`endif
      .clr(clr)
   );

   always #5 clock = ~clock;

   // Reference model state
   logic [31:0] m_q[$];
   logic [7:0]  m_ptr;
   bit          m_err, m_sticky, m_wrap;
   int          m_wcnt;

   int op_tab [22] = '{0,0,0,1,1,1,2,2,2,2,5,7,9,10,12,13,14,15,16,17,18,19};
   int fn_tab [10] = '{1,2,3,1,2,4,1,2,3,4};

   function automatic logic [31:0] model_word(input int sel, input int rs, input int rt,
         input int rd, input int sa, input int imm, input int tgt);
      int w;
      w = op_tab[sel] * 67108864;                       // op << 26
      if (sel <= 5)       w = w + rs*2097152 + rt*65536 + rd*2048 + fn_tab[sel];
      else if (sel <= 8)  w = w + rt*65536 + rd*2048 + sa*64 + fn_tab[sel];
      else if (sel == 9)  w = w + rs*2097152 + fn_tab[sel];
      else if (sel <= 18) w = w + rs*2097152 + rt*65536 + imm;
      else if (sel == 19) w = w + rt*65536 + imm;
      else                w = w + tgt;
      return 32'(w);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_ptr = 8'd0; m_err = 1'b0; m_sticky = 1'b0; m_wrap = 1'b0; m_wcnt = 0;
   endtask

   // Advance one clock; inputs were driven after the previous negedge.
   task automatic tick();
      bit acc, ok, pop, wset;
      logic [31:0] w;
      acc  = in_valid && (m_q.size() < 2);
      ok   = (in_sel < 5'd22);
      pop  = (m_q.size() > 0) && im_ready;
      wset = pop && !ld_addr && (m_ptr == 8'hFF);
      w    = ok ? model_word(int'(in_sel), int'(in_rs), int'(in_rt), int'(in_rd),
                             int'(in_sa), int'(in_imm), int'(in_target)) : 32'd0;
      @(posedge clock);
      if (pop) void'(m_q.pop_front());
      if (acc && ok) m_q.push_back(w);
      m_err = acc && !ok;
      if (m_err) m_sticky = 1'b1; else if (clr) m_sticky = 1'b0;
      if (wset) m_wrap = 1'b1; else if (clr) m_wrap = 1'b0;
      if (ld_addr) m_ptr = addr_in; else if (pop) m_ptr = m_ptr + 8'd1;
      if (clr) m_wcnt = 0; else if (pop && m_wcnt < 65535) m_wcnt = m_wcnt + 1;
      @(negedge clock);
   endtask

   task automatic drive_req(input int sel, input int rs, input int rt, input int rd,
                            input int sa, input int imm, input int tgt);
      in_valid = 1'b1; in_sel = 5'(sel); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
      in_sa = 5'(sa); in_imm = 16'(imm); in_target = 26'(tgt);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; ld_addr = 1'b0; clr = 1'b0; im_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clock);
      resetn = 1'b0;
      model_reset();
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL reset_im_we got=%b exp=0", im_we); end
      checks++; if (im_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", im_wdata); end
      checks++; if (im_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", im_addr); end
      checks++; if ({err, err_sticky, wrapped} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {err, err_sticky, wrapped}); end
`ifdef PIPE_ENC_CNT_EN
      checks++; if (wcount !== 16'd0) begin errors++; $display("FAIL reset_wcount got=%0d exp=0", wcount); end
`endif
      resetn = 1'b1;
   endtask

   task automatic test_directed();
      do_reset();
      im_ready = 1'b1;
      drive_req(0, 1, 2, 3, 0, 0, 0);
      tick(); in_valid = 1'b0;
      checks++; if (im_we !== 1'b1 || im_wdata !== 32'h00221801 || im_addr !== 8'h00) begin
         errors++; $display("FAIL add_word got we=%b %h@%h exp 1 00221801@00", im_we, im_wdata, im_addr); end
      tick();
      checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL add_drain got we=%b exp=0", im_we); end

      do_reset();
      im_ready = 1'b1;
      drive_req(15, 4, 5, 0, 0, 8, 0);
      tick();
      drive_req(21, 0, 0, 0, 0, 0, 32'h100);
      checks++; if (im_wdata !== 32'h34850008 || im_addr !== 8'h00 || im_we !== 1'b1) begin
         errors++; $display("FAIL lw_word got %h@%h exp 34850008@00", im_wdata, im_addr); end
      tick(); in_valid = 1'b0;
      checks++; if (im_wdata !== 32'h4C000100 || im_addr !== 8'h01 || im_we !== 1'b1) begin
         errors++; $display("FAIL jal_word got %h@%h exp 4C000100@01", im_wdata, im_addr); end
      tick();

      drive_req(8, 9, 2, 7, 4, 0, 0);
      tick(); in_valid = 1'b0;
      checks++; if (im_wdata !== 32'h08023903) begin errors++; $display("FAIL sll_word got=%h exp=08023903", im_wdata); end
      tick();
      drive_req(9, 31, 5, 0, 0, 0, 0);
      tick(); in_valid = 1'b0;
      // jr: op=000010, func=000100, rt/rd/sa forced to zero
      checks++; if (im_wdata !== 32'h0BE00004) begin errors++; $display("FAIL jr_word got=%h exp=0BE00004", im_wdata); end
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_w [3];
      logic [31:0] hold_w;
      logic [7:0]  hold_a;
      do_reset();
      exp_w[0] = model_word(3, 1, 2, 3, 0, 0, 0);
      exp_w[1] = model_word(12, 6, 7, 0, 0, 16'hBEEF, 0);
      exp_w[2] = model_word(20, 0, 0, 0, 0, 0, 26'h3ABCDEF);
      drive_req(3, 1, 2, 3, 0, 0, 0);            tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
      drive_req(12, 6, 7, 0, 0, 16'hBEEF, 0);    tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b exp=0", in_ready); end
      hold_w = im_wdata; hold_a = im_addr;
      drive_req(20, 0, 0, 0, 0, 0, 26'h3ABCDEF); tick(); tick();
      checks++; if (im_wdata !== hold_w || im_addr !== hold_a || im_we !== 1'b1 || hold_w !== exp_w[0]) begin
         errors++; $display("FAIL bp_stable got %h@%h exp %h@%h", im_wdata, im_addr, exp_w[0], hold_a); end
      in_valid = 1'b0; im_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checks++; if (im_we !== 1'b1 || im_wdata !== exp_w[i] || im_addr !== 8'(i)) begin
            errors++; $display("FAIL bp_drain%0d got %h@%h exp %h@%h", i, im_wdata, im_addr, exp_w[i], i); end
         tick();
      end
      checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL bp_empty got we=%b exp=0", im_we); end
      // third request was held while full, then dropped: it must never appear
      checks++; if (m_q.size() != 0 || im_wdata === exp_w[2]) begin errors++; $display("FAIL bp_third got=%h", im_wdata); end
   endtask

   task automatic test_invalid();
      do_reset();
      im_ready = 1'b1;
      drive_req(25, 1, 1, 1, 1, 1, 1);
      tick(); in_valid = 1'b0;
      checks++; if (im_we !== 1'b0 || err !== 1'b1 || err_sticky !== 1'b1) begin
         errors++; $display("FAIL inv_pulse got we=%b err=%b sticky=%b exp 0 1 1", im_we, err, err_sticky); end
      tick();
      checks++; if (err !== 1'b0 || err_sticky !== 1'b1) begin
         errors++; $display("FAIL inv_after got err=%b sticky=%b exp 0 1", err, err_sticky); end
      clr = 1'b1; tick(); clr = 1'b0;
      checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL inv_clr got=%b exp=0", err_sticky); end
      drive_req(30, 0, 0, 0, 0, 0, 0); clr = 1'b1;
      tick(); in_valid = 1'b0; clr = 1'b0;
      checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL inv_set_wins got=%b exp=1", err_sticky); end
   endtask

   task automatic test_wrap();
      do_reset();
      ld_addr = 1'b1; addr_in = 8'hFF; tick(); ld_addr = 1'b0;
      im_ready = 1'b1;
      drive_req(1, 3, 4, 5, 0, 0, 0); tick();
      drive_req(13, 2, 2, 0, 0, 16'h1234, 0);
      checks++; if (im_addr !== 8'hFF || im_wdata !== model_word(1, 3, 4, 5, 0, 0, 0)) begin
         errors++; $display("FAIL wrap_first got %h@%h exp addr ff", im_wdata, im_addr); end
      tick(); in_valid = 1'b0;
      checks++; if (im_addr !== 8'h00 || wrapped !== 1'b1) begin
         errors++; $display("FAIL wrap_second got addr=%h wrapped=%b exp 00 1", im_addr, wrapped); end
      tick();
`ifdef PIPE_ENC_CNT_EN
      checks++; if (wcount !== 16'd2) begin errors++; $display("FAIL wrap_wcount got=%0d exp=2", wcount); end
`endif
      checks++; if (im_addr !== 8'h01) begin errors++; $display("FAIL wrap_next got=%h exp=01", im_addr); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      drive_req(2, 1, 1, 1, 0, 0, 0); tick();
      drive_req(4, 2, 2, 2, 0, 0, 0); tick(); in_valid = 1'b0;
      #2 resetn = 1'b0;
      model_reset();
      #1;
      checks++; if (im_we !== 1'b0 || im_addr !== 8'h00 || in_ready !== 1'b1) begin
         errors++; $display("FAIL midreset got we=%b addr=%h ready=%b exp 0 00 1", im_we, im_addr, in_ready); end
      @(negedge clock); resetn = 1'b1;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         checks++; if (in_ready !== (m_q.size() < 2) || im_we !== (m_q.size() > 0)) begin
            errors++; $display("FAIL rnd_hs it=%0d got ready=%b we=%b exp size=%0d", i, in_ready, im_we, m_q.size()); end
         if (m_q.size() > 0) begin
            checks++; if (im_wdata !== m_q[0]) begin errors++; $display("FAIL rnd_data it=%0d got=%h exp=%h", i, im_wdata, m_q[0]); end
         end
         checks++; if (im_addr !== m_ptr) begin errors++; $display("FAIL rnd_addr it=%0d got=%h exp=%h", i, im_addr, m_ptr); end
         checks++; if ({err, err_sticky, wrapped} !== {m_err, m_sticky, m_wrap}) begin
            errors++; $display("FAIL rnd_flags it=%0d got=%b exp=%b", i, {err, err_sticky, wrapped}, {m_err, m_sticky, m_wrap}); end
`ifdef PIPE_ENC_CNT_EN
         checks++; if (wcount !== 16'(m_wcnt)) begin errors++; $display("FAIL rnd_wcount it=%0d got=%0d exp=%0d", i, wcount, m_wcnt); end
`endif
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sel    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 21));
         in_rs     = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom); in_sa = 5'($urandom);
         in_imm    = 16'($urandom); in_target = 26'($urandom);
         im_ready  = ($urandom_range(0, 2) != 0);
         ld_addr   = ($urandom_range(0, 15) == 0);
         addr_in   = ($urandom_range(0, 1) == 1) ? 8'hFE : 8'($urandom);
         clr       = ($urandom_range(0, 15) == 0);
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_invalid();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
